// File: rtl/bt_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module : bt_cmd_pkg
// Brief  : Frame constants, command codes and parser state encoding
// Rev    : 1.0
// ============================================================================
package bt_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CHK_KEY   = 8'h5A;

  localparam logic [7:0] CMD_JUMP  = 8'h4A;
  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_DUCK  = 8'h44;
  localparam logic [7:0] CMD_PAUSE = 8'h50;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    WAIT_CMD  = 2'd1,
    WAIT_CHK  = 2'd2
  } state_t;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_JUMP) || (cmd == CMD_START) ||
           (cmd == CMD_DUCK) || (cmd == CMD_PAUSE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bt_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module : bt_cmd_parser_if
// Brief  : Receiver byte input and game-command outputs of the parser
// Rev    : 1.0
// ============================================================================
interface bt_cmd_parser_if;
  logic [7:0] RxData;
  logic       RxDone;
  logic       jump_pulse;
  logic       start_pulse;
  logic       duck;
  logic       paused;
  logic       frame_err;
  logic [7:0] last_cmd;

  modport master (
    output RxData, RxDone,
    input  jump_pulse, start_pulse, duck, paused, frame_err, last_cmd
  );

  modport slave (
    input  RxData, RxDone,
    output jump_pulse, start_pulse, duck, paused, frame_err, last_cmd
  );
endinterface
`default_nettype wire

// File: rtl/bt_cmd_parser_rx_done_edge.sv
`default_nettype none
// ============================================================================
// Module : rx_done_edge
// Brief  : Synchronises RxDone and emits a one-cycle strobe per rising edge
// Rev    : 1.0
// ============================================================================
module rx_done_edge (
  input  wire logic Clk,
  input  wire logic Rst_n,
  input  wire logic RxDone,
  output logic      byte_stb
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_stb;

  // Registered strobe places byte_stb three cycles after the RxDone rise
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_sync1 <= RxDone;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_stb   <= r_sync2 & ~r_sync3;
    end
  end

  assign byte_stb = r_stb;

endmodule
`default_nettype wire

// File: rtl/bt_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module : bt_cmd_parser
// Brief  : Validates {SYNC,CMD,CHK} frames and drives dino game commands
// Rev    : 1.0
// ============================================================================
module bt_cmd_parser
  import bt_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 500000,
  parameter int unsigned DUCK_HOLD_CYC = 5000000
) (
  input wire logic        Clk,
  input wire logic        Rst_n,
  bt_cmd_parser_if.slave  bus
);

  localparam int unsigned GAP_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DUCK_W = $clog2(DUCK_HOLD_CYC + 1);
  localparam logic [GAP_W-1:0]  C_GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]  C_GAP_MAX  = GAP_W'(TIMEOUT_CYC);
  localparam logic [DUCK_W-1:0] C_DUCK_LD  = DUCK_W'(DUCK_HOLD_CYC);

  logic              w_byte_stb;
  logic [7:0]        w_byte_q;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cmd_q;
  logic [GAP_W-1:0]  r_gap;
  logic [DUCK_W-1:0] r_duck_cnt;
  logic              w_cmd_ld;
  logic              w_act;
  logic              w_err;
  logic              w_timeout;

  logic              r_jump;
  logic              r_start;
  logic              r_duck;
  logic              r_paused;
  logic              r_err;
  logic [7:0]        r_last_cmd;

  rx_done_edge u_rx_done_edge (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .RxDone   (bus.RxDone),
    .byte_stb (w_byte_stb)
  );

  // RxData is held stable while RxDone is high, so it is read directly on the strobe
  assign w_byte_q = bus.RxData;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= WAIT_SYNC;
      r_cmd_q <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_ld) begin
        r_cmd_q <= w_byte_q;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ld    = 1'b0;
    w_act       = 1'b0;
    w_err       = 1'b0;
    w_timeout   = (r_state != WAIT_SYNC) && !w_byte_stb && (r_gap == C_GAP_LAST);
    if (w_byte_stb) begin
      case (r_state)
        WAIT_SYNC: begin
          if (w_byte_q == SYNC_BYTE) begin
            w_state_nxt = WAIT_CMD;
          end
        end
        WAIT_CMD: begin
          if (w_byte_q != SYNC_BYTE) begin
            w_cmd_ld    = 1'b1;
            w_state_nxt = WAIT_CHK;
          end
        end
        WAIT_CHK: begin
          w_state_nxt = WAIT_SYNC;
          if ((w_byte_q == (r_cmd_q ^ CHK_KEY)) && is_known_cmd(r_cmd_q)) begin
            w_act = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_nxt = WAIT_SYNC;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = WAIT_SYNC;
      w_err       = 1'b1;
    end
  end

  // Inter-byte gap timer; idle in WAIT_SYNC so it starts fresh with each frame
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_gap <= '0;
    end else if (w_byte_stb || (w_state_nxt == WAIT_SYNC)) begin
      r_gap <= '0;
    end else if (r_gap != C_GAP_MAX) begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_jump     <= 1'b0;
      r_start    <= 1'b0;
      r_paused   <= 1'b0;
      r_err      <= 1'b0;
      r_last_cmd <= 8'h00;
    end else begin
      r_jump  <= w_act && (r_cmd_q == CMD_JUMP);
      r_start <= w_act && (r_cmd_q == CMD_START);
      r_err   <= w_err;
      if (w_act) begin
        r_last_cmd <= r_cmd_q;
      end
      if (w_act && (r_cmd_q == CMD_PAUSE)) begin
        r_paused <= ~r_paused;
      end else if (w_act && (r_cmd_q == CMD_START)) begin
        r_paused <= 1'b0;
      end
    end
  end

  // Duck hold: a repeat 'D' reloads the counter, so the level never dips
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_duck     <= 1'b0;
      r_duck_cnt <= '0;
    end else if (w_act && (r_cmd_q == CMD_DUCK)) begin
      r_duck     <= 1'b1;
      r_duck_cnt <= C_DUCK_LD;
    end else if (r_duck_cnt > DUCK_W'(1)) begin
      r_duck_cnt <= r_duck_cnt - DUCK_W'(1);
    end else if (r_duck_cnt == DUCK_W'(1)) begin
      r_duck_cnt <= '0;
      r_duck     <= 1'b0;
    end
  end

  assign bus.jump_pulse  = r_jump;
  assign bus.start_pulse = r_start;
  assign bus.duck        = r_duck;
  assign bus.paused      = r_paused;
  assign bus.frame_err   = r_err;
  assign bus.last_cmd    = r_last_cmd;

endmodule
`default_nettype wire
